// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single unified memory port between the IF stage (loads only)
//   and the MEM stage (loads and stores). A granted access is held on the bus
//   for MEM_LAT cycles, then the owner's done pulses for one cycle and read data
//   is passed through. Stalls are asserted while a request has not completed.
//
//   Optional feature: define ARB_RR_EN to break IF/DMEM ties round-robin
//   against last_grant. When it is undefined, DMEM always wins a tie.
//
// Parameters:
//   MEM_LAT  memory latency in cycles (1..15)
//   CNT_W    latency counter width (2**CNT_W > MEM_LAT)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req, if_addr          fetch request and address
//   if_done, if_rdata        fetch completion pulse and instruction
//   if_stall                 if_req & ~if_done
//   dmem_command/addr/wdata  data request (00 none, 01 load, 10 store)
//   dmem_done, dmem_rdata    data completion pulse and load data
//   dmem_stall               request pending & ~dmem_done
//   proc2mem_command/addr/data  memory bus, zero/none when idle
//   mem2proc_data            memory read data, valid in the last access cycle
//   grant_owner              00 idle, 01 IF, 10 DMEM
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic [1:0]  dmem_command,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_done,
  output logic [31:0] dmem_rdata,
  output logic        dmem_stall,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  output logic [31:0] proc2mem_data,
  input  logic [31:0] mem2proc_data,
  output logic [1:0]  grant_owner
);

  localparam logic [1:0] BUS_NONE  = 2'b00;
  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_IF    = 2'b01;
  localparam logic [1:0] OWN_DMEM  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             d_req;
  logic             pick_d;
  logic             pick_i;
  logic             last_cycle;

`ifdef ARB_RR_EN
  logic [1:0] last_grant;
`endif

  // Arbitration decision, only acted on while IDLE.
  always_comb begin
    d_req  = (dmem_command != BUS_NONE);
`ifdef ARB_RR_EN
    // On a tie DMEM wins only if IF was the previous owner.
    pick_d = d_req & (~if_req | (last_grant == OWN_IF));
`else
    pick_d = d_req;
`endif
    pick_i = if_req & ~pick_d;
  end

  // The holding registers are the bus outputs; they are cleared on the way
  // back to IDLE so the bus reads BUS_NONE/0 whenever the FSM is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      proc2mem_command <= BUS_NONE;
      proc2mem_addr    <= '0;
      proc2mem_data    <= '0;
      grant_owner      <= OWN_NONE;
`ifdef ARB_RR_EN
      last_grant       <= OWN_IF;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state            <= BUSY_D;
            cnt              <= CNT_W'(MEM_LAT - 1);
            proc2mem_command <= dmem_command;
            proc2mem_addr    <= dmem_addr;
            proc2mem_data    <= dmem_wdata;
            grant_owner      <= OWN_DMEM;
`ifdef ARB_RR_EN
            last_grant       <= OWN_DMEM;
`endif
          end else if (pick_i) begin
            state            <= BUSY_I;
            cnt              <= CNT_W'(MEM_LAT - 1);
            proc2mem_command <= BUS_LOAD;
            proc2mem_addr    <= if_addr;
            proc2mem_data    <= '0;
            grant_owner      <= OWN_IF;
`ifdef ARB_RR_EN
            last_grant       <= OWN_IF;
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          if (cnt == '0) begin
            state            <= IDLE;
            proc2mem_command <= BUS_NONE;
            proc2mem_addr    <= '0;
            proc2mem_data    <= '0;
            grant_owner      <= OWN_NONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    last_cycle = (cnt == '0);
    if_done    = (state == BUSY_I) && last_cycle;
    dmem_done  = (state == BUSY_D) && last_cycle;
    if_rdata   = if_done ? mem2proc_data : '0;
    dmem_rdata = (dmem_done && (proc2mem_command == BUS_LOAD)) ? mem2proc_data : '0;
    if_stall   = if_req & ~if_done;
    dmem_stall = d_req & ~dmem_done;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (MEM_LAT=2). Inputs change 1 time
// unit after each rising edge; outputs are checked 1 unit later still.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic [1:0]  dmem_command;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_done;
  logic [31:0] dmem_rdata;
  logic        dmem_stall;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [31:0] proc2mem_data;
  logic [31:0] mem2proc_data;
  logic [1:0]  grant_owner;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.MEM_LAT(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .dmem_command(dmem_command), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_done(dmem_done), .dmem_rdata(dmem_rdata), .dmem_stall(dmem_stall),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_data(mem2proc_data),
    .grant_owner(grant_owner)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req       = 1'b0;
    if_addr      = '0;
    dmem_command = 2'b00;
    dmem_addr    = '0;
    dmem_wdata   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0200;
    dmem_command = 2'b10; dmem_addr = 32'h0000_1000; dmem_wdata = 32'h1234_5678;
    mem2proc_data = 32'hAAAA_5555;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #1;
      n_cmp++; if (proc2mem_command !== 2'b00) begin n_err++; $display("FAIL rst_cmd[%0d]: got %b want 00", i, proc2mem_command); end
      n_cmp++; if ({if_done, dmem_done} !== 2'b00) begin n_err++; $display("FAIL rst_done[%0d]: got %b want 00", i, {if_done, dmem_done}); end
      n_cmp++; if (grant_owner !== 2'b00) begin n_err++; $display("FAIL rst_owner[%0d]: got %b want 00", i, grant_owner); end
      n_cmp++; if ({if_stall, dmem_stall} !== 2'b11) begin n_err++; $display("FAIL rst_stall[%0d]: got %b want 11", i, {if_stall, dmem_stall}); end
      n_cmp++; if ({proc2mem_addr, proc2mem_data, if_rdata, dmem_rdata} !== 128'h0) begin n_err++; $display("FAIL rst_zero[%0d]: got %h want 0", i, {proc2mem_addr, proc2mem_data, if_rdata, dmem_rdata}); end
    end
    // Release reset: this IDLE cycle samples the tie, DMEM wins (first tie).
    next_cycle(); rst = 1'b0; #1;
    n_cmp++; if (proc2mem_command !== 2'b00) begin n_err++; $display("FAIL rst_release_idle: got %b want 00", proc2mem_command); end
    next_cycle(); idle_inputs(); #1;
    n_cmp++; if (proc2mem_command !== 2'b10) begin n_err++; $display("FAIL rst_store_grant_cmd: got %b want 10", proc2mem_command); end
    n_cmp++; if (grant_owner !== 2'b10) begin n_err++; $display("FAIL rst_store_grant_owner: got %b want 10", grant_owner); end
    n_cmp++; if (proc2mem_addr !== 32'h0000_1000) begin n_err++; $display("FAIL rst_store_addr: got %h want 00001000", proc2mem_addr); end
    next_cycle(); #1;
    n_cmp++; if (dmem_done !== 1'b1) begin n_err++; $display("FAIL rst_store_done: got %b want 1", dmem_done); end
    next_cycle(); #1;
    n_cmp++; if (proc2mem_command !== 2'b00) begin n_err++; $display("FAIL rst_store_back_idle: got %b want 00", proc2mem_command); end
  endtask

  task automatic test_lone_fetch();
    idle_inputs();
    if_req = 1'b1; if_addr = 32'h0000_0100; mem2proc_data = 32'h0000_0013;
    #1;
    n_cmp++; if (if_stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall_c0: got %b want 1", if_stall); end
    next_cycle(); #1;
    n_cmp++; if (proc2mem_command !== 2'b01) begin n_err++; $display("FAIL fetch_cmd_c1: got %b want 01", proc2mem_command); end
    n_cmp++; if (proc2mem_addr !== 32'h0000_0100) begin n_err++; $display("FAIL fetch_addr_c1: got %h want 00000100", proc2mem_addr); end
    n_cmp++; if ({if_stall, if_done} !== 2'b10) begin n_err++; $display("FAIL fetch_stall_done_c1: got %b want 10", {if_stall, if_done}); end
    n_cmp++; if (grant_owner !== 2'b01) begin n_err++; $display("FAIL fetch_owner_c1: got %b want 01", grant_owner); end
    next_cycle(); #1;
    n_cmp++; if (proc2mem_command !== 2'b01 || proc2mem_addr !== 32'h0000_0100) begin n_err++; $display("FAIL fetch_bus_c2: got %b/%h want 01/00000100", proc2mem_command, proc2mem_addr); end
    n_cmp++; if (if_done !== 1'b1) begin n_err++; $display("FAIL fetch_done_c2: got %b want 1", if_done); end
    n_cmp++; if (if_rdata !== 32'h0000_0013) begin n_err++; $display("FAIL fetch_rdata_c2: got %h want 00000013", if_rdata); end
    n_cmp++; if (if_stall !== 1'b0) begin n_err++; $display("FAIL fetch_stall_c2: got %b want 0", if_stall); end
    next_cycle(); idle_inputs(); #1;
    n_cmp++; if (proc2mem_command !== 2'b00 || proc2mem_addr !== 32'h0) begin n_err++; $display("FAIL fetch_idle_c3: got %b/%h want 00/00000000", proc2mem_command, proc2mem_addr); end
    n_cmp++; if (if_rdata !== 32'h0) begin n_err++; $display("FAIL fetch_rdata_c3: got %h want 00000000", if_rdata); end
    next_cycle(); #1;
  endtask

  task automatic test_tie_fixed();
    idle_inputs();
    if_req = 1'b1; if_addr = 32'h0000_0104;
    dmem_command = 2'b10; dmem_addr = 32'h0000_2000; dmem_wdata = 32'hDEAD_BEEF;
    mem2proc_data = 32'h5555_0001;
    next_cycle(); #1;
    n_cmp++; if (proc2mem_command !== 2'b10 || proc2mem_addr !== 32'h0000_2000) begin n_err++; $display("FAIL tie_store_c1: got %b/%h want 10/00002000", proc2mem_command, proc2mem_addr); end
    n_cmp++; if (proc2mem_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL tie_wdata_c1: got %h want deadbeef", proc2mem_data); end
    n_cmp++; if ({if_stall, dmem_stall} !== 2'b11) begin n_err++; $display("FAIL tie_stalls_c1: got %b want 11", {if_stall, dmem_stall}); end
    next_cycle(); #1;
    n_cmp++; if (dmem_done !== 1'b1 || if_done !== 1'b0) begin n_err++; $display("FAIL tie_done_c2: got d%b i%b want d1 i0", dmem_done, if_done); end
    n_cmp++; if (dmem_rdata !== 32'h0) begin n_err++; $display("FAIL tie_store_rdata_c2: got %h want 00000000", dmem_rdata); end
    n_cmp++; if (proc2mem_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL tie_wdata_c2: got %h want deadbeef", proc2mem_data); end
    next_cycle(); dmem_command = 2'b00; #1;
    n_cmp++; if (proc2mem_command !== 2'b00 || grant_owner !== 2'b00) begin n_err++; $display("FAIL tie_idle_c3: got %b/%b want 00/00", proc2mem_command, grant_owner); end
    next_cycle(); #1;
    n_cmp++; if (proc2mem_command !== 2'b01 || proc2mem_addr !== 32'h0000_0104) begin n_err++; $display("FAIL tie_if_c4: got %b/%h want 01/00000104", proc2mem_command, proc2mem_addr); end
    n_cmp++; if (proc2mem_data !== 32'h0) begin n_err++; $display("FAIL tie_if_data_c4: got %h want 00000000", proc2mem_data); end
    next_cycle(); #1;
    n_cmp++; if (if_done !== 1'b1 || if_rdata !== 32'h5555_0001) begin n_err++; $display("FAIL tie_if_done_c5: got %b/%h want 1/55550001", if_done, if_rdata); end
    next_cycle(); idle_inputs(); #1;
    next_cycle(); #1;
  endtask

  task automatic test_dropped_request();
    idle_inputs();
    dmem_command = 2'b01; dmem_addr = 32'h0000_3000; mem2proc_data = 32'hCAFE_F00D;
    next_cycle(); dmem_command = 2'b00; #1;
    n_cmp++; if (proc2mem_command !== 2'b01 || proc2mem_addr !== 32'h0000_3000) begin n_err++; $display("FAIL drop_bus_c1: got %b/%h want 01/00003000", proc2mem_command, proc2mem_addr); end
    next_cycle(); #1;
    n_cmp++; if (proc2mem_command !== 2'b01 || proc2mem_addr !== 32'h0000_3000) begin n_err++; $display("FAIL drop_bus_c2: got %b/%h want 01/00003000", proc2mem_command, proc2mem_addr); end
    n_cmp++; if (dmem_done !== 1'b1) begin n_err++; $display("FAIL drop_done_c2: got %b want 1", dmem_done); end
    n_cmp++; if (dmem_rdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL drop_rdata_c2: got %h want cafef00d", dmem_rdata); end
    n_cmp++; if (dmem_stall !== 1'b0) begin n_err++; $display("FAIL drop_stall_c2: got %b want 0", dmem_stall); end
    next_cycle(); #1;
    n_cmp++; if (proc2mem_command !== 2'b00 || dmem_done !== 1'b0) begin n_err++; $display("FAIL drop_idle_c3: got %b/%b want 00/0", proc2mem_command, dmem_done); end
  endtask

  task automatic test_back_to_back_ties();
    logic [1:0] want_second;
`ifdef ARB_RR_EN
    want_second = 2'b01;
`else
    want_second = 2'b10;
`endif
    idle_inputs();
    rst = 1'b1;
    next_cycle(); rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0108;
    dmem_command = 2'b01; dmem_addr = 32'h0000_4000;
    next_cycle(); #1;
    n_cmp++; if (grant_owner !== 2'b10) begin n_err++; $display("FAIL tie1_owner: got %b want 10", grant_owner); end
    next_cycle(); #1;
    next_cycle(); #1;
    n_cmp++; if (grant_owner !== 2'b00) begin n_err++; $display("FAIL tie_gap_owner: got %b want 00", grant_owner); end
    next_cycle(); #1;
    n_cmp++; if (grant_owner !== want_second) begin n_err++; $display("FAIL tie2_owner: got %b want %b", grant_owner, want_second); end
    next_cycle(); idle_inputs(); #1;
    next_cycle(); #1;
    n_cmp++; if (proc2mem_command !== 2'b00) begin n_err++; $display("FAIL tie2_back_idle: got %b want 00", proc2mem_command); end
  endtask

  task automatic test_mid_access_reset();
    idle_inputs();
    dmem_command = 2'b10; dmem_addr = 32'h0000_5000; dmem_wdata = 32'h0BAD_F00D;
    next_cycle(); rst = 1'b1; #1;
    n_cmp++; if (proc2mem_command !== 2'b10) begin n_err++; $display("FAIL mrst_store_c1: got %b want 10", proc2mem_command); end
    next_cycle(); rst = 1'b0; #1;
    n_cmp++; if (proc2mem_command !== 2'b00 || dmem_done !== 1'b0) begin n_err++; $display("FAIL mrst_abort_c2: got %b/%b want 00/0", proc2mem_command, dmem_done); end
    n_cmp++; if (grant_owner !== 2'b00) begin n_err++; $display("FAIL mrst_owner_c2: got %b want 00", grant_owner); end
    next_cycle(); #1;
    n_cmp++; if (proc2mem_command !== 2'b10 || proc2mem_data !== 32'h0BAD_F00D) begin n_err++; $display("FAIL mrst_reissue_c3: got %b/%h want 10/0badf00d", proc2mem_command, proc2mem_data); end
    n_cmp++; if (dmem_done !== 1'b0) begin n_err++; $display("FAIL mrst_early_done_c3: got %b want 0", dmem_done); end
    next_cycle(); #1;
    n_cmp++; if (dmem_done !== 1'b1) begin n_err++; $display("FAIL mrst_reissue_done_c4: got %b want 1", dmem_done); end
    next_cycle(); idle_inputs(); #1;
    next_cycle(); #1;
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_tie_fixed();
    test_dropped_request();
    test_back_to_back_ties();
    test_mid_access_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the processor's single unified memory port between the IF stage (instruction fetch, loads only) and the MEM stage (data loads and stores). Each granted access is held stable on the memory bus for a fixed number of cycles. The arbiter then signals completion with a one-cycle done pulse and returns read data. While a requester's access is outstanding, it drives that requester's stall, which freezes the corresponding pipeline registers.

## Interface
Parameters:
- MEM_LAT, 2: memory access latency in cycles; legal range 1..15.
- CNT_W, 4: width of the latency counter; must satisfy 2^CNT_W > MEM_LAT.

Ports:
- clk  in  1  system clock
- rst  in  1  system reset, synchronous, active-high
- if_req  in  1  IF fetch request
- if_addr  in  32  IF fetch address
- if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  32  fetched instruction
- if_stall  out  1  if_req & ~if_done
- dmem_command  in  2  BUS_NONE=2'b00 (no request), BUS_LOAD=2'b01, BUS_STORE=2'b10
- dmem_addr  in  32  data address
- dmem_wdata  in  32  store data
- dmem_done  out  1  one-cycle pulse: data access complete
- dmem_rdata  out  32  load data, valid with dmem_done
- dmem_stall  out  1  (dmem_command != BUS_NONE) & ~dmem_done
- proc2mem_command  out  2  command to memory
- proc2mem_addr  out  32  address to memory
- proc2mem_data  out  32  store data to memory
- mem2proc_data  in  32  read data from memory, valid in the last cycle of an access
- grant_owner  out  2  00 idle, 01 IF, 10 DMEM (debug)

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE samples the requests. In the cycle rst is high, requests are ignored.
  - Only one requester active: that requester is granted.
  - Both active: DMEM is granted (see Configuration).
  - Neither active: stay in IDLE.
- On grant, the following are latched into holding registers:
  - address
  - command (IF always BUS_LOAD)
  - write data (IF: 0)
- At grant, the counter is loaded with MEM_LAT-1.
- In a BUSY state, the holding registers drive proc2mem_*. The counter decrements each cycle.
- When counter==0 in BUSY:
  - Assert the owner's done, combinationally.
  - Pass mem2proc_data through to the owner's rdata. rdata is 0 when done is low; for stores dmem_rdata is 0.
  - Next state is IDLE.
- Requester input changes during BUSY are ignored. A request dropped mid-access still completes, and done still pulses; stores are never cancelled.
- IDLE always inserts one cycle between accesses, so the requester sees its next request fresh.
- proc2mem_command is BUS_NONE, and proc2mem_addr/data are 0, whenever the FSM is in IDLE.
- last_grant register records the most recent owner. Reset value is IF.

## Timing
- Request visible in IDLE in cycle 0 → memory driven in cycles 1..MEM_LAT → done in cycle MEM_LAT.
- Throughput: one access per MEM_LAT+1 cycles.
- A losing requester is granted no earlier than 1 cycle after the winner's done.
- Reset values:
  - state IDLE, counter 0, last_grant IF
  - proc2mem_command BUS_NONE; proc2mem_addr/data 0
  - if_done and dmem_done 0; if_rdata and dmem_rdata 0
  - grant_owner 00
  - Stalls follow their equations, i.e. equal the requests.
- Reset mid-access aborts the access: the next cycle is IDLE with BUS_NONE, and no done is issued.
- The MEM_LAT=1 boundary: counter loaded with 0, so done occurs in cycle 1.

## Configuration
- ARB_RR_EN defined: on a tie in IDLE, the requester that is not last_grant wins (round-robin).
- ARB_RR_EN undefined: on a tie, DMEM always wins, and last_grant is unused.
- In both modes the first tie after reset grants DMEM.

## Test plan
- Reset, MEM_LAT=2:
  - Hold rst 3 cycles with if_req=1 and dmem_command=BUS_STORE.
  - Required: proc2mem_command=00, both dones 0, grant_owner=00.
  - After rst falls, the store is granted in the next cycle.
- Lone fetch:
  - Stimulus: if_req=1, if_addr=0x100 in cycle 0; memory returns 0x00000013.
  - Required: cycles 1-2 show command BUS_LOAD, addr 0x100.
  - Required: cycle 2 shows if_done=1 and if_rdata=0x13.
  - Required: if_stall=1 in cycles 0-1, 0 in cycle 2.
- Tie, fixed priority:
  - Stimulus: if_req (0x104) and BUS_STORE 0x2000/0xDEADBEEF together in cycle 0.
  - Required: STORE driven cycles 1-2 with proc2mem_data=0xDEADBEEF; dmem_done in cycle 2.
  - Required: IDLE in cycle 3, IF LOAD 0x104 in cycles 4-5, if_done in cycle 5.
- Dropped request:
  - Stimulus: BUS_LOAD 0x3000 granted, then dmem_command=BUS_NONE in cycle 1.
  - Required: access still drives through cycle 2, and dmem_done pulses in cycle 2.
- ARB_RR_EN defined:
  - Stimulus: two consecutive ties.
  - Required: the first tie grants DMEM and the second grants IF.
  - Repeat without the macro: both ties grant DMEM.
- Mid-access reset:
  - Stimulus: rst in cycle 1 of a BUSY_D store.
  - Required: cycle 2 shows BUS_NONE and no dmem_done.
  - Required: a store reissued afterwards completes in MEM_LAT cycles.
